// File: rtl/barrel_shifter_if.sv
// Barrel shifter operand/result bundle.
//   dir     : 0 = left, 1 = right
//   op      : 0 = shift, 1 = rotate
//   shift_t : 0 = logical, 1 = arithmetic (meaningful for right shifts only)
//   sel     : shift amount, 0..W-1
//   in      : operand (two's complement)
//   out     : registered result (two's complement)
// master drives the operation, slave (the shifter) returns out.
interface barrel_shifter_if #(
  parameter int W     = 8,
  parameter int LOG2W = 3
);
  logic             dir;
  logic             op;
  logic             shift_t;
  logic [LOG2W-1:0] sel;
  logic [W-1:0]     in;
  logic [W-1:0]     out;

  modport master (output dir, op, shift_t, sel, in, input  out);
  modport slave  (input  dir, op, shift_t, sel, in, output out);
endinterface

// File: rtl/barrel_shifter.sv
// Registered log-depth barrel shifter, one result per cycle, 1-cycle latency.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears out
//   bus : barrel_shifter_if.slave (dir/op/shift_t/sel/in in, out out)
// Datapath is LOG2W cascaded mux stages; stage i moves the word by 2^i when
// sel[i] is set. Only the output register holds state.

// One cascade stage: move by AMT positions or pass through.
module barrel_shifter_stage #(
  parameter int W   = 8,
  parameter int AMT = 1
) (
  input  logic [W-1:0] d,
  input  logic         en,
  input  logic         dir,
  input  logic         rot,
  input  logic         arith,
  output logic [W-1:0] q
);
  logic [AMT-1:0] lfill, rfill;

  // Left fill: wrapped-out MSBs for rotate, zeros for shift.
  assign lfill = rot ? d[W-1:W-AMT] : '0;
  // Right fill: wrapped-out LSBs for rotate, sign copies for arithmetic,
  // else zeros. d[W-1] is still the original sign bit here because earlier
  // arithmetic stages only ever fill with that same bit.
  assign rfill = rot   ? d[AMT-1:0] :
                 arith ? {AMT{d[W-1]}} : '0;

  always_comb begin
    q = d;
    if (en) q = dir ? {rfill, d[W-1:AMT]} : {d[W-AMT-1:0], lfill};
  end
endmodule

module barrel_shifter #(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  logic                clk,
  input  logic                rst,
  barrel_shifter_if.slave     bus
);
  logic [LOG2W:0][W-1:0] stg;
  logic                  arith;
  logic [W-1:0]          out_q;

  // shift_t only matters for a right shift.
  assign arith  = bus.shift_t & bus.dir & ~bus.op;
  assign stg[0] = bus.in;

  for (genvar i = 0; i < LOG2W; i++) begin : g_stage
    barrel_shifter_stage #(.W(W), .AMT(1 << i)) u_stage (
      .d     (stg[i]),
      .en    (bus.sel[i]),
      .dir   (bus.dir),
      .rot   (bus.op),
      .arith (arith),
      .q     (stg[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= stg[LOG2W];
  end

  assign bus.out = out_q;
endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter (W=8): stimulus is driven on the falling
// edge with its expected result queued; the monitor pops and compares one
// expectation per rising edge, #1 after the edge.
module tb_barrel_shifter;
  localparam int W     = 8;
  localparam int LOG2W = 3;

  typedef struct {
    logic [W-1:0] exp;
    string        tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  sb[$];

  barrel_shifter_if #(.W(W), .LOG2W(LOG2W)) bus ();

  barrel_shifter #(.W(W), .LOG2W(LOG2W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference: plain operators, rotate via a doubled word.
  function automatic logic [W-1:0] ref_model(input logic d, input logic o, input logic s,
                                             input logic [LOG2W-1:0] sl, input logic [W-1:0] x);
    logic [2*W-1:0] dbl;
    dbl = {x, x};
    if (o) begin
      if (d) begin dbl = dbl >> sl; return dbl[W-1:0];     end
      else   begin dbl = dbl << sl; return dbl[2*W-1:W];   end
    end
    if (!d) return x << sl;
    if (s)  return W'($signed(x) >>> sl);
    return x >> sl;
  endfunction

  task automatic drive(input logic r, input logic d, input logic o, input logic s,
                       input logic [LOG2W-1:0] sl, input logic [W-1:0] x,
                       input logic [W-1:0] exp, input string tag);
    @(negedge clk);
    rst         = r;
    bus.dir     = d;
    bus.op      = o;
    bus.shift_t = s;
    bus.sel     = sl;
    bus.in      = x;
    sb.push_back('{exp, tag});
  endtask

  // Operation with the expected value taken from the reference model.
  task automatic op_m(input logic d, input logic o, input logic s,
                      input logic [LOG2W-1:0] sl, input logic [W-1:0] x, input string tag);
    drive(1'b0, d, o, s, sl, x, ref_model(d, o, s, sl, x), tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.tag, bus.out, e.exp);
    end
  end

  initial begin
    logic [13:0] v;
    bus.dir = 1'b0; bus.op = 1'b0; bus.shift_t = 1'b0;
    bus.sel = '0;   bus.in = '0;

    // Reset for two edges with a nonzero operand present.
    drive(1'b1, 0, 0, 0, 3'd0, 8'hFF, 8'h00, "rst_0");
    drive(1'b1, 0, 0, 0, 3'd0, 8'hFF, 8'h00, "rst_1");
    // First edge out of reset loads immediately.
    drive(1'b0, 0, 0, 0, 3'd1, 8'h81, 8'h02, "rst_release");

    // Directed values.
    drive(1'b0, 0, 0, 0, 3'd3, 8'h96, 8'hB0, "shl_st0");
    drive(1'b0, 0, 0, 1, 3'd3, 8'h96, 8'hB0, "shl_st1");
    drive(1'b0, 1, 0, 0, 3'd3, 8'h96, 8'h12, "shr_log");
    drive(1'b0, 1, 0, 1, 3'd3, 8'h96, 8'hF2, "shr_ari");
    drive(1'b0, 1, 0, 1, 3'd7, 8'h7F, 8'h00, "shr_ari_max_pos");
    drive(1'b0, 1, 0, 1, 3'd7, 8'h80, 8'hFF, "shr_ari_max_neg");
    drive(1'b0, 0, 0, 0, 3'd7, 8'h01, 8'h80, "shl_max");
    drive(1'b0, 0, 1, 0, 3'd3, 8'h96, 8'hB4, "rotl");
    drive(1'b0, 1, 1, 0, 3'd3, 8'h96, 8'hD2, "rotr");
    drive(1'b0, 0, 1, 1, 3'd3, 8'h96, 8'hB4, "rotl_st1");
    drive(1'b0, 1, 1, 1, 3'd3, 8'h96, 8'hD2, "rotr_st1");
    drive(1'b0, 1, 1, 0, 3'd7, 8'h01, 8'h02, "rotr_max");

    // sel=0 is identity for every control combination.
    for (int c = 0; c < 8; c++)
      drive(1'b0, c[2], c[1], c[0], 3'd0, 8'hA5, 8'hA5, "sel0_ident");

    // Reset mid-stream drops the pending result; next edge resumes cleanly.
    op_m(0, 1, 0, 3'd5, 8'h3C, "pre_midrst");
    drive(1'b1, 1, 1, 0, 3'd2, 8'h3C, 8'h00, "midrst");
    op_m(1, 1, 0, 3'd2, 8'h3C, "post_midrst");

    // Exhaustive sweep, one vector per cycle.
    for (int i = 0; i < (1 << 14); i++) begin
      v = 14'(i);
      op_m(v[13], v[12], v[11], v[10:8], v[7:0], "sweep");
    end

    // Every queued expectation must have been consumed.
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 8'(sb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/barrel_shifter.md
BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 Parameter W, default 8: data width in bits; SHALL be a power of two, at least 2.
REQ-002 Parameter LOG2W, default 3: shift-amount width; SHALL equal log2(W).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 dir  input  1  direction: 0 = left, 1 = right.
REQ-006 op  input  1  operation: 0 = shift, 1 = rotate.
REQ-007 shift_t  input  1  shift type: 0 = logical, 1 = arithmetic; ignored when op=1.
REQ-008 sel  input  LOG2W  shift amount, unsigned, 0..W-1.
REQ-009 in  input  W  operand, two's-complement signed.
REQ-010 out  output  W  result, signed, registered.

Function
REQ-011 Latency SHALL be exactly 1 cycle: out after rising edge k reflects dir/op/shift_t/sel/in sampled at edge k.
REQ-012 No handshake; a new operation SHALL be accepted every cycle, throughput 1 result/cycle.
REQ-013 Left shift (dir=0, op=0): out = (in << sel) truncated to W bits, zeros into LSBs; shift_t SHALL have no effect.
REQ-014 Right logical shift (dir=1, op=0, shift_t=0): out = in >> sel, zeros into MSBs.
REQ-015 Right arithmetic shift (dir=1, op=0, shift_t=1): out = in >>> sel, copies of in[W-1] into MSBs.
REQ-016 Rotate left (dir=0, op=1): out = (in << sel) | (in >> (W-sel)), bits leaving MSB re-enter at LSB.
REQ-017 Rotate right (dir=1, op=1): out = (in >> sel) | (in << (W-sel)), bits leaving LSB re-enter at MSB.
REQ-018 sel=0 SHALL give out = in for every dir/op/shift_t combination.
REQ-019 sel=W-1 SHALL be handled without special casing: left shift keeps only in[0] at MSB; arithmetic right yields all sign bits or sign bit plus nothing else (0x00 or 0xFF for W=8).
REQ-020 Datapath SHALL be LOG2W cascaded mux stages; stage i shifts/rotates by 2^i when sel[i]=1, else passes through; fill value per stage per REQ-013..017.
REQ-021 Datapath SHALL be purely combinational between input pins and the single output register; no other state.
REQ-022 Output SHALL never be X/Z when all inputs are known.

Reset
REQ-023 While rst=1 at a rising edge, out SHALL become all zeros at that edge, regardless of other inputs.
REQ-024 First edge with rst=0 SHALL load the result of the then-present inputs (no extra recovery cycle).
REQ-025 Reset asserted mid-stream SHALL discard the pending result; no partial result SHALL appear.
REQ-026 Before the first reset out is undefined; the bench SHALL apply rst for at least one edge.

Verification (W=8, LOG2W=3; result checked one cycle after applying inputs)
REQ-027 rst=1 for 2 edges, in=0xFF -> out=0x00; release -> next edge reflects inputs.
REQ-028 in=0x96, sel=3, dir=0, op=0, shift_t=0 or 1 -> out=0xB0; dir=1, op=0, shift_t=0 -> out=0x12.
REQ-029 in=0x96, sel=3, dir=1, op=0, shift_t=1 -> out=0xF2; in=0x7F, sel=7, same controls -> out=0x00; in=0x80 -> out=0xFF.
REQ-030 in=0x96, sel=3, op=1: dir=0 -> out=0xB4; dir=1 -> out=0xD2; shift_t toggled -> unchanged.
REQ-031 sel=0, all 8 control combinations, in=0xA5 -> out=0xA5.
REQ-032 Exhaustive sweep: all dir/op/shift_t/sel/in (2^14 vectors), one per cycle, compared against a reference model of REQ-013..017 with 1-cycle delay -> zero mismatches.
